// File: rtl/store_buffer_pkg.sv
// Shared store/load definitions: funct3 encodings and byte-lane helpers.
// Also imported by the load writeback extractor.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef logic [3:0] strb_t;

endpackage

// File: rtl/store_align.sv
// Combinational store aligner: replicates store data across byte lanes,
// builds byte strobes and flags misaligned or unknown store encodings.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output strb_t       wstrb_o,
  output logic        err_o
);

  // Lane replication, strobe generation and alignment check per store size.
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    err_o   = 1'b0;
    case (funct3_i)
      F3_SB: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      F3_SH: begin
        if (addr_lo_i[0]) begin
          err_o = 1'b1;
        end else begin
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{data_i[15:0]}};
        end
      end
      F3_SW: begin
        if (addr_lo_i != 2'b00) begin
          err_o = 1'b1;
        end else begin
          wstrb_o = 4'b1111;
          wdata_o = data_i;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them in a DEPTH-entry FIFO
// and drains them to the data-memory write port with valid/ready.
// Optional macro STORE_FWD_EN enables the load/store word-address hazard
// compare on ld_hazard; without it ld_hazard is constant 0.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_funct3,
  output logic          st_err,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_err_q, st_err_d;

  // Entry storage is intentionally not reset; validity comes from count_q.
  logic [AW-3:0] waddr_q [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  strb_t         wstrb_q [DEPTH];

  logic [31:0] al_wdata;
  strb_t       al_wstrb;
  logic        al_err;
  logic        accept, push, pop, full;

  store_align u_align (
    .addr_lo_i (st_addr[1:0]),
    .funct3_i  (st_funct3),
    .data_i    (st_data),
    .wdata_o   (al_wdata),
    .wstrb_o   (al_wstrb),
    .err_o     (al_err)
  );

  assign full       = (count_q == CW'(DEPTH));
  assign st_ready   = !full;
  assign accept     = st_valid && st_ready;
  assign push       = accept && !al_err;
  assign mem_wvalid = (count_q != '0);
  assign idle       = (count_q == '0);
  assign pop        = mem_wvalid && mem_wready;
  assign st_err     = st_err_q;

  assign mem_waddr = {waddr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = wdata_q[rd_ptr_q];
  assign mem_wstrb = wstrb_q[rd_ptr_q];

  // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    st_err_d = accept && al_err;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; async reset discards all pending stores immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  // Entry write on enqueue; held unchanged until popped, giving AXI-style hold.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr_q] <= st_addr[AW-1:2];
      wdata_q[wr_ptr_q] <= al_wdata;
      wstrb_q[wr_ptr_q] <= al_wstrb;
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] hz_off;

  // Word-address match of the load against every live entry and the incoming store.
  always_comb begin
    ld_hazard = push && (st_addr[AW-1:2] == ld_addr[AW-1:2]);
    hz_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_off = PW'(i) - rd_ptr_q;
      if ((CW'(hz_off) < count_q) && (waddr_q[i] == ld_addr[AW-1:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hazard      = 1'b0;
`endif

endmodule
